// File: rtl/intersection_sequencer.sv
// Purpose: N-channel traffic-light sequencer (green/yellow/all-red per granted channel, round-robin + preferential, flashing attention).
// Latency: all outputs registered; every input reacts on the next rising edge.
// Backpressure: none; inputs are level-sampled requests, outputs are free-running lamp drives.
//
// Ports:
//   clk, rst         : single clock, synchronous active-high reset
//   attention        : level, forces flashing-yellow mode while high
//   force_red[N]     : per channel, hold red and exclude from selection
//   preferential[N]  : per channel, priority request sampled at selection
//   leds[N][2:0]     : per channel {green, yellow, red}
//   active_ch        : channel currently or last granted
//   phase_start      : one-cycle pulse on the first green cycle
module intersection_sequencer #(
  parameter int N_CH     = 4,
  parameter int TW       = 8,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int CLEAR_T  = 2,
  parameter int FLASH_T  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      attention,
  input  logic [N_CH-1:0]           force_red,
  input  logic [N_CH-1:0]           preferential,
  output logic [N_CH-1:0][2:0]      leds,
  output logic [$clog2(N_CH)-1:0]   active_ch,
  output logic                      phase_start
);

  localparam int CW  = $clog2(N_CH);
  // One extra bit so the flash wrap point (2*FLASH_T-1) always fits.
  localparam int TCW = TW + 1;

  localparam logic [TCW-1:0] CLR_LAST = TCW'(CLEAR_T - 1);
  localparam logic [TCW-1:0] GRN_LAST = TCW'(GREEN_T - 1);
  localparam logic [TCW-1:0] YEL_LAST = TCW'(YELLOW_T - 1);
  localparam logic [TCW-1:0] FL_HALF  = TCW'(FLASH_T);
  localparam logic [TCW-1:0] FL_LAST  = TCW'(2 * FLASH_T - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_e;

  state_e                state_q,  state_d;
  logic [TCW-1:0]        timer_q,  timer_d;
  logic [CW-1:0]         active_q, active_d;
  logic                  first_q,  first_d;   // no grant yet since reset: search starts at ch0
  logic [N_CH-1:0][2:0]  leds_q,   leds_d;
  logic                  phase_q,  phase_d;

  // ---------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------
  logic [N_CH-1:0] elig;
  logic            any_elig;
  logic            pref_hit;
  logic [CW-1:0]   pref_ch;
  logic [CW-1:0]   rr_ch;
  logic [CW-1:0]   sel_ch;

  assign elig     = ~force_red;
  assign any_elig = |elig;

  always_comb begin : sel_logic
    int rr_start;
    int idx;
    pref_hit = 1'b0;
    pref_ch  = '0;
    rr_ch    = '0;
    rr_start = 0;
    idx      = 0;

    // Descending scan so the lowest matching index is written last.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (elig[i] && preferential[i]) begin
        pref_hit = 1'b1;
        pref_ch  = CW'(i);
      end
    end

    // Round-robin from active_ch+1; active_ch itself is the last candidate.
    if (!first_q) begin
      rr_start = int'(active_q) + 1;
      if (rr_start >= N_CH) rr_start = 0;
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = rr_start + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (elig[idx]) rr_ch = CW'(idx);
    end

    sel_ch = pref_hit ? pref_ch : rr_ch;
  end

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      timer_q  <= '0;
      active_q <= '0;
      first_q  <= 1'b1;
      leds_q   <= {N_CH{3'b001}};
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      first_q  <= first_d;
      leds_q   <= leds_d;
      phase_q  <= phase_d;
    end
  end

  // ---------------------------------------------------------------
  // Next state; outputs are derived from the next state so they are
  // registered yet change on the same edge as the state.
  // ---------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    active_d = active_q;
    first_d  = first_q;
    phase_d  = 1'b0;
    leds_d   = {N_CH{3'b001}};

    if (attention) begin
      if (state_q != S_FLASH) begin
        state_d = S_FLASH;
        timer_d = '0;
        first_d = 1'b0;
      end else if (timer_q == FL_LAST) begin
        timer_d = '0;
      end
    end else begin
      unique case (state_q)
        S_CLEAR: begin
          if (timer_q >= CLR_LAST) begin
            if (any_elig) begin
              state_d  = S_GREEN;
              timer_d  = '0;
              active_d = sel_ch;
              first_d  = 1'b0;
              phase_d  = 1'b1;
            end else begin
              // Hold at the expiry point so a released channel is granted on the next edge.
              timer_d = CLR_LAST;
            end
          end
        end
        S_GREEN: begin
          if (force_red[active_q] || (timer_q == GRN_LAST)) begin
            state_d = S_YELLOW;
            timer_d = '0;
          end
        end
        S_YELLOW: begin
          if (timer_q == YEL_LAST) begin
            state_d = S_CLEAR;
            timer_d = '0;
          end
        end
        S_FLASH: begin
          state_d = S_CLEAR;
          timer_d = '0;
        end
        default: begin
          state_d = S_CLEAR;
          timer_d = '0;
        end
      endcase
    end

    unique case (state_d)
      S_GREEN:  leds_d[active_d] = 3'b100;
      S_YELLOW: leds_d[active_d] = 3'b010;
      S_FLASH:  leds_d = (timer_d < FL_HALF) ? {N_CH{3'b010}} : {N_CH{3'b000}};
      default:  leds_d = {N_CH{3'b001}};
    endcase
  end

  assign leds        = leds_q;
  assign active_ch   = active_q;
  assign phase_start = phase_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Bench for intersection_sequencer: directed scenarios followed by random
// stimulus, all compared cycle by cycle against a countdown-based model.
module tb_intersection_sequencer;

  localparam int N  = 4;
  localparam int GT = 8;
  localparam int YT = 3;
  localparam int CT = 2;
  localparam int FT = 4;

  localparam int M_RED = 0;
  localparam int M_GRN = 1;
  localparam int M_YEL = 2;
  localparam int M_FL  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                attention;
  logic [N-1:0]        force_red;
  logic [N-1:0]        preferential;
  logic [N-1:0][2:0]   leds;
  logic [1:0]          active_ch;
  logic                phase_start;

  always #5 clk = ~clk;

  intersection_sequencer #(
    .N_CH(N), .TW(8), .GREEN_T(GT), .YELLOW_T(YT), .CLEAR_T(CT), .FLASH_T(FT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .attention(attention),
    .force_red(force_red),
    .preferential(preferential),
    .leds(leds),
    .active_ch(active_ch),
    .phase_start(phase_start)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each lamp phase is a countdown of cycles remaining; flash tracks its age.
  int  m_mode  = M_RED;
  int  m_left  = CT;
  int  m_ch    = 0;
  int  m_age   = 0;
  bit  m_fresh = 1'b1;
  bit  m_pulse = 1'b0;
  bit  m_valid = 1'b0;

  function automatic int choose(input logic [N-1:0] fr, input logic [N-1:0] pf);
    int q[$];
    int base;
    for (int i = 0; i < N; i++)
      if (pf[i] && !fr[i]) q.push_back(i);
    base = m_fresh ? 0 : m_ch + 1;
    for (int k = 0; k < N; k++)
      if (!fr[(base + k) % N]) q.push_back((base + k) % N);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  task automatic model_step(input logic r, input logic a, input logic [N-1:0] fr, input logic [N-1:0] pf);
    int c;
    m_pulse = 1'b0;
    if (r) begin
      m_valid = 1'b1;
      m_mode  = M_RED;
      m_left  = CT;
      m_ch    = 0;
      m_fresh = 1'b1;
    end else if (!m_valid) begin
      m_mode = M_RED;
    end else if (a) begin
      if (m_mode != M_FL) begin
        m_mode  = M_FL;
        m_age   = 0;
        m_fresh = 1'b0;
      end else begin
        m_age++;
      end
    end else begin
      case (m_mode)
        M_FL: begin
          m_mode = M_RED;
          m_left = CT;
        end
        M_RED: begin
          if (m_left <= 1) begin
            c = choose(fr, pf);
            if (c >= 0) begin
              m_mode  = M_GRN;
              m_left  = GT;
              m_ch    = c;
              m_fresh = 1'b0;
              m_pulse = 1'b1;
            end
          end else begin
            m_left--;
          end
        end
        M_GRN: begin
          if (fr[m_ch] || m_left == 1) begin
            m_mode = M_YEL;
            m_left = YT;
          end else begin
            m_left--;
          end
        end
        default: begin
          if (m_left == 1) begin
            m_mode = M_RED;
            m_left = CT;
          end else begin
            m_left--;
          end
        end
      endcase
    end
  endtask

  function automatic logic [N-1:0][2:0] exp_leds();
    logic [N-1:0][2:0] v;
    for (int i = 0; i < N; i++) v[i] = 3'b001;
    case (m_mode)
      M_GRN: v[m_ch] = 3'b100;
      M_YEL: v[m_ch] = 3'b010;
      M_FL:  for (int i = 0; i < N; i++) v[i] = ((m_age % (2 * FT)) < FT) ? 3'b010 : 3'b000;
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    model_step(rst, attention, force_red, preferential);
    #1;
    if (m_valid) begin
      check("leds", leds, exp_leds());
      check("active_ch", active_ch, m_ch);
      check("phase_start", phase_start, m_pulse);
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_cyc(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int gcyc[5];
    gcyc = '{2, 15, 28, 41, 54};
    rst = 1'b1; attention = 1'b0; force_red = '0; preferential = '0;
    repeat (3) @(negedge clk);
    check("rst_leds", leds, 32'h249);
    check("rst_active", active_ch, 0);
    check("rst_phase", phase_start, 0);
    rst = 1'b0;
    cyc = 0;

    // Plain rotation: greens at fixed 13-cycle slots
    for (int j = 0; j < 5; j++) begin
      to_cyc(gcyc[j] - 1);
      check("rot_no_pulse", phase_start, 0);
      to_cyc(gcyc[j]);
      check("rot_pulse", phase_start, 1);
      check("rot_ch", active_ch, j % 4);
    end

    // Preferential override
    to_cyc(55);
    preferential = 4'b1000;
    to_cyc(67);
    check("pref_ch3", active_ch, 3);
    check("pref_pulse", phase_start, 1);
    preferential = '0;
    to_cyc(80);
    check("pref_resume_ch0", active_ch, 0);

    // force_red on active green, plus skip of ch2
    to_cyc(95);
    check("fr_ch1_green", leds, 32'h261);
    force_red = 4'b0110;
    to_cyc(96);
    check("fr_yellow", leds, 32'h251);
    force_red = 4'b0100;
    to_cyc(100);
    check("fr_allred", leds, 32'h249);
    to_cyc(101);
    check("fr_skip_ch3", active_ch, 3);
    check("fr_skip_pulse", phase_start, 1);

    // All channels forced red
    force_red = 4'hF;
    to_cyc(115);
    check("allred_pulse", phase_start, 0);
    check("allred_leds", leds, 32'h249);
    force_red = 4'b1011;
    to_cyc(116);
    check("release_ch2", active_ch, 2);
    check("release_pulse", phase_start, 1);
    force_red = '0;

    // Attention raised mid-yellow
    to_cyc(124);
    check("att_pre_yellow", leds, 32'h289);
    attention = 1'b1;
    to_cyc(125);
    check("flash_on", leds, 32'h492);
    to_cyc(129);
    check("flash_off", leds, 32'h000);
    to_cyc(133);
    check("flash_on2", leds, 32'h492);
    to_cyc(136);
    attention = 1'b0;
    to_cyc(138);
    check("att_clear", leds, 32'h249);
    to_cyc(139);
    check("att_resume_ch3", active_ch, 3);
    check("att_resume_pulse", phase_start, 1);

    // Reset mid-green on ch2
    to_cyc(178);
    check("pre_rst_ch2", active_ch, 2);
    to_cyc(180);
    rst = 1'b1;
    to_cyc(181);
    check("midrst_leds", leds, 32'h249);
    check("midrst_active", active_ch, 0);
    rst = 1'b0;
    to_cyc(182);
    check("midrst_wait", phase_start, 0);
    to_cyc(183);
    check("midrst_restart", phase_start, 1);
    check("midrst_leds_ch0", leds, 32'h24C);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cyc++;
      rst = ($urandom_range(0, 199) == 0);
      if (attention) begin
        if ($urandom_range(0, 11) == 0) attention = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        attention = 1'b1;
      end
      if ($urandom_range(0, 9) == 0)
        force_red = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 149) == 0)
        force_red = '1;
      preferential = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/intersection_sequencer.md
# intersection_sequencer

Parametrised N-channel traffic-light sequencer that generalises the fixed four-light controller. Each selected channel runs a complete green, yellow and all-red clearance cycle. Channels are chosen round-robin, with preferential override, per-channel force-red and skip, and a global flashing-attention mode. It sits at top level and drives all approach lamp groups of one intersection directly from a single clock domain.

## Interface
- N_CH, 4: number of approach channels (2..16)
- TW, 8: phase timer width
- GREEN_T, 8: green duration in cycles (1..2^TW-1)
- YELLOW_T, 3: yellow duration in cycles (1..2^TW-1)
- CLEAR_T, 2: all-red clearance duration in cycles (1..2^TW-1)
- FLASH_T, 4: attention blink half-period in cycles (1..2^TW-1)
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- attention  in  1  level; enter flashing-yellow mode
- force_red  in  N_CH  per channel; hold channel red, never select it
- preferential  in  N_CH  per channel; priority request, sampled at selection
- leds  out  N_CH x 3  per channel {green, yellow, red} = bits [2:0]; red is bit 0; registered
- active_ch  out  $clog2(N_CH)  channel currently or last granted
- phase_start  out  1  one-cycle pulse on the cycle green first appears

## Operation
- States: CLEAR (all red), GREEN, YELLOW, FLASH. The timer counts cycles spent in the current state and is zeroed on every state entry.
- Reset values: state CLEAR, timer 0, active_ch 0, phase_start 0, every leds[i] = 3'b001. The initial selection starts the search at channel 0; it does not start from active_ch+1.
- CLEAR exits when timer == CLEAR_T-1 and an eligible channel exists. Eligible means force_red[i] == 0.
  - Winner: lowest-index eligible channel with preferential set.
  - Otherwise: the first eligible channel searching upward from active_ch+1, modulo N_CH. This includes active_ch itself, last.
  - Next state is GREEN on the winner; active_ch is updated.
- If no channel is eligible, stay in CLEAR. The timer saturates at CLEAR_T-1 and selection is re-evaluated every cycle.
- GREEN exits to YELLOW when timer == GREEN_T-1, or on the next edge after force_red[active_ch] is seen high.
- YELLOW always runs the full YELLOW_T and then goes to CLEAR. force_red does not shorten it.
- Only active_ch is ever non-red. All other channels show 3'b001.
- attention high, sampled at any edge and in any state, moves to FLASH on that edge with timer 0.
  - In FLASH every channel shows 3'b010 for FLASH_T cycles, then 3'b000 for FLASH_T cycles, repeating. The timer wraps at 2*FLASH_T-1.
  - force_red is ignored in FLASH.
- attention low while in FLASH moves to CLEAR with a full CLEAR_T. Selection then resumes normally, starting from active_ch+1.
- Priority of simultaneous events: rst > attention > force_red > timer expiry.
- phase_start is high exactly on the first GREEN cycle. It is 0 otherwise, including after reset and in FLASH.

## Timing
- leds, active_ch and phase_start are registered and change on the edge that changes state. They have no combinational path from the inputs.
- After the edge where rst goes low, CLEAR holds for CLEAR_T cycles, then green.
- Per-channel slot with no overrides: GREEN_T + YELLOW_T + CLEAR_T cycles. With defaults this is 13 cycles, and a full 4-channel rotation is 52 cycles.
- Reaction latencies:
  - force_red on the active green: yellow visible 1 edge later.
  - attention: flashing visible 1 edge later.
- Reset asserted mid-phase returns all outputs to reset values on that edge.

## Test plan
- Defaults, no requests: green on ch0 at cycle 2, ch1 at 15, ch2 at 28, ch3 at 41, ch0 at 54. phase_start pulses at each of these cycles; yellow lasts 3 cycles and all-red 2.
- preferential[3] held high while ch0 is green: the next green is ch3, not ch1. After ch3 completes with preferential low, the sequence continues at ch0.
- force_red[1] pulsed during ch1 green at timer 2: yellow appears next cycle for 3 cycles, then 2 cycles of all-red, then ch2 green. With force_red[2] also held high, ch2 is skipped and ch3 is granted.
- All force_red bits high: every channel stays red and phase_start stays 0. Releasing force_red[2] gives ch2 green on the next edge, because the clearance period has already elapsed.
- attention raised mid-yellow: the next cycle shows all channels 3'b010 for 4 cycles, then 3'b000 for 4 cycles, repeating. Dropping attention gives 2 cycles of all-red, then green on active_ch+1.
- rst asserted mid-green on ch2: all channels show 3'b001 and active_ch is 0 on the next edge. The sequence restarts on ch0 two cycles after rst drops.
